// File: rtl/frame_region_reader.sv
// frame_region_reader
//   Reads a rectangular region of the 160x120, 3-bit-colour video memory
//   through its synchronous read port. The region is emitted as a raster-order
//   pixel stream (x, y, colour) with a valid/ready handshake.
//
//   The region is clipped to the screen when start is accepted. Reads are
//   throttled so that the 2-entry output buffer cannot overflow under
//   backpressure.
//
//   Optional feature (macro FRAME_REGION_MATCH_COUNT_EN): counts the
//   transferred pixels whose colour equals match_colour, which is latched at
//   start.
//
// Ports
//   CLOCK_50     in   system clock; all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle request, sampled only in IDLE
//   x0, y0       in   region top-left corner
//   w, h         in   region size in pixels
//   mem_addr     out  video memory read address (y*160 + x)
//   mem_q        in   read data, valid one cycle after mem_addr
//   pix_valid    out  output pixel available
//   pix_ready    in   consumer accepts the pixel when pix_valid & pix_ready
//   pix_x/y      out  coordinates of the current output pixel
//   pix_colour   out  stored colour of the current output pixel
//   match_colour in   colour to count (only with FRAME_REGION_MATCH_COUNT_EN)
//   match_count  out  number of matching pixels transferred (only with the macro)
//   busy         out  high from the accepted start until done
//   done         out  one-cycle pulse after the last pixel transfers
//
// States
//   IDLE   | waiting for start
//   SCAN   | issuing reads over the clipped region
//   DRAIN  | last read issued; waiting for the pipe and buffer to empty
//   FINISH | done pulse, then return to IDLE
module frame_region_reader #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             x0,
  input  logic [6:0]             y0,
  input  logic [7:0]             w,
  input  logic [6:0]             h,
  output logic [14:0]            mem_addr,
  input  logic [COLOUR_BITS-1:0] mem_q,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [7:0]             pix_x,
  output logic [6:0]             pix_y,
  output logic [COLOUR_BITS-1:0] pix_colour,
`ifdef FRAME_REGION_MATCH_COUNT_EN
  input  logic [COLOUR_BITS-1:0] match_colour,
  output logic [14:0]            match_count,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam logic [8:0] X_LIM   = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM   = 8'(SCREEN_H);
  localparam int         ENTRY_W = 15 + COLOUR_BITS;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;
  state_t state_q, state_d;

  logic [7:0] cx, x_first, x_last;
  logic [6:0] cy, y_last;
  logic       inflight;
  logic [7:0] tag_x;
  logic [6:0] tag_y;

  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] head;

  // Sums are one bit wider than the operands so they cannot wrap.
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic [7:0] x_end_c;
  logic [6:0] y_end_c;
  logic       region_empty, accept, last_pix, issue, push, pop;
  logic [1:0] occ;

  assign x_sum        = {1'b0, x0} + {1'b0, w};
  assign y_sum        = {1'b0, y0} + {1'b0, h};
  assign x_end_c      = (x_sum > X_LIM) ? X_LIM[7:0] : x_sum[7:0];
  assign y_end_c      = (y_sum > Y_LIM) ? Y_LIM[6:0] : y_sum[6:0];
  assign region_empty = (w == 8'd0) || (h == 7'd0) ||
                        ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
  assign accept       = (state_q == IDLE) && start;

  assign last_pix = (cx == x_last) && (cy == y_last);
  assign push     = inflight;
  assign pop      = pix_valid && pix_ready;
  assign occ      = fifo_count + {1'b0, inflight};
  // A slot freed by this cycle's pop counts as free. The data for a read
  // issued now lands one edge later, after that pop has happened, so the
  // buffer still cannot overflow. Counting the pop is what allows one pixel
  // per cycle when pix_ready is held high.
  assign issue    = (state_q == SCAN) && ((occ < 2'd2) || pop);

  // The address is y*128 + y*32 + x, which equals y*160 + x.
  assign mem_addr = {1'b0, cy, 7'b0} + {3'b0, cy, 5'b0} + {7'b0, cx};

  assign head       = fifo_mem[rd_ptr];
  assign pix_valid  = (fifo_count != 2'd0);
  assign pix_x      = head[ENTRY_W-1 -: 8];
  assign pix_y      = head[COLOUR_BITS +: 7];
  assign pix_colour = head[COLOUR_BITS-1:0];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = region_empty ? FINISH : SCAN;
      SCAN:    if (issue && last_pix) state_d = DRAIN;
      DRAIN:   if (!inflight && fifo_count == 2'd0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN) || (state_q == DRAIN);
    done = (state_q == FINISH);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cx          <= '0;
      cy          <= '0;
      x_first     <= '0;
      x_last      <= '0;
      y_last      <= '0;
      inflight    <= 1'b0;
      tag_x       <= '0;
      tag_y       <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
    end else begin
      if (accept) begin
        cx      <= x0;
        cy      <= y0;
        x_first <= x0;
        x_last  <= x_end_c - 8'd1;
        y_last  <= y_end_c - 7'd1;
      end else if (issue && !last_pix) begin
        // On the last pixel cx/cy are not advanced, so mem_addr keeps the
        // final read address.
        if (cx == x_last) begin
          cx <= x_first;
          cy <= cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end

      inflight <= issue;
      if (issue) begin
        tag_x <= cx;
        tag_y <= cy;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= {tag_x, tag_y, mem_q};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef FRAME_REGION_MATCH_COUNT_EN
  logic [COLOUR_BITS-1:0] match_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      match_q     <= '0;
      match_count <= '0;
    end else if (accept) begin
      match_q     <= match_colour;
      match_count <= '0;
    end else if (pop && (pix_colour == match_q)) begin
      match_count <= match_count + 15'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_region_reader.sv
module tb_frame_region_reader;
  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int NPIX = SW * SH;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  x0, w;
  logic [6:0]  y0, h;
  logic [14:0] mem_addr;
  logic [2:0]  mem_q = 3'd0;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic        busy, done;
`ifdef FRAME_REGION_MATCH_COUNT_EN
  logic [2:0]  match_colour;
  logic [14:0] match_count;
`endif

  frame_region_reader dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .w           (w),
    .h           (h),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
`ifdef FRAME_REGION_MATCH_COUNT_EN
    .match_colour(match_colour),
    .match_count (match_count),
`endif
    .busy        (busy),
    .done        (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous-read video memory model.
  logic [2:0] mem [NPIX];
  always @(posedge CLOCK_50)
    mem_q <= (mem_addr < 15'(NPIX)) ? mem[mem_addr] : 3'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Buffer overflow guard: a landing read with a full buffer and no pop.
  always @(posedge CLOCK_50) begin
    if (reset_n && (dut.fifo_count > 2'd2 ||
                    (dut.inflight && !dut.pop && dut.fifo_count == 2'd2))) begin
      n_fail++;
      $display("FAIL fifo_overflow: count=%0d inflight=%0d pop=%0d, required no push into full buffer",
               dut.fifo_count, dut.inflight, dut.pop);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  typedef struct {
    int x0, y0, w, h;
    int exp_n;        // pixels expected
    int exp_addr;     // first read address (when exp_n > 0)
    int ready_mode;   // 0 always, 1 pattern 1,0,0 repeating, 2 random
    int busy_restart; // cycle index at which start is pulsed while busy, -1 none
    int finish_start; // pulse start during the FINISH cycle
  } vec_t;

  task automatic run_vec(input vec_t v);
    int xe, ye, ex, ey, got, first_valid, done_cnt;
    bit stall_prev;
    int prev_pix;
    int act_pix;
    xe = (v.x0 + v.w > SW) ? SW : v.x0 + v.w;
    ye = (v.y0 + v.h > SH) ? SH : v.y0 + v.h;
    ex = v.x0; ey = v.y0;
    got = 0; first_valid = -1; done_cnt = 0; stall_prev = 0; prev_pix = 0;

    x0 = 8'(v.x0); y0 = 7'(v.y0); w = 8'(v.w); h = 7'(v.h);
    pix_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), (v.exp_n > 0) ? 1 : 0);
    if (v.exp_n > 0) check("first_mem_addr", int'(mem_addr), v.exp_addr);

    for (int cyc = 0; cyc < NPIX + 200; cyc++) begin
      case (v.ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 3 == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      start = 1'b0;
      if (cyc == v.busy_restart) begin
        start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd5; h = 7'd5;
      end
      act_pix = int'({pix_x, pix_y, pix_colour});
      if (stall_prev) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_stable", act_pix, prev_pix);
      end
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (pix_valid && pix_ready) begin
        if (ey < ye)
          check("pixel", act_pix, (ex << 10) | (ey << 3) | int'(mem[ey * SW + ex]));
        got++;
        ex++;
        if (ex == xe) begin ex = v.x0; ey++; end
      end
      stall_prev = pix_valid && !pix_ready;
      prev_pix   = act_pix;
      if (done) begin
        done_cnt++;
        if (v.finish_start != 0) begin
          start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd2; h = 7'd2;
        end
        tick();
        start = 1'b0;
        break;
      end
      tick();
    end
    start = 1'b0;
    pix_ready = 1'b1;

    check("done_seen", done_cnt, 1);
    check("pixel_count", got, v.exp_n);
    check("first_valid_cycle", first_valid, (v.exp_n > 0) ? 2 : -1);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    if (v.exp_n > 0) check("last_mem_addr", int'(mem_addr), (ye - 1) * SW + xe - 1);
    if (v.finish_start != 0) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check("finish_start_ignored", int'({busy, pix_valid, done}), 0);
      end
    end
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{0,   0,   160, 120, 19200, 0,     0, -1, 0};
    vecs[1]  = '{80,  10,  3,   2,   6,     1680,  0, -1, 0};
    vecs[2]  = '{80,  10,  3,   2,   6,     1680,  1, -1, 0};
    vecs[3]  = '{158, 118, 10,  10,  4,     19038, 0, -1, 0};
    vecs[4]  = '{5,   5,   0,   4,   0,     0,     0, -1, 0};
    vecs[5]  = '{5,   5,   4,   0,   0,     0,     0, -1, 0};
    vecs[6]  = '{160, 5,   4,   4,   0,     0,     0, -1, 0};
    vecs[7]  = '{5,   120, 4,   4,   0,     0,     0, -1, 0};
    vecs[8]  = '{0,   0,   1,   1,   1,     0,     0, -1, 0};
    vecs[9]  = '{10,  20,  5,   3,   15,    3210,  2, -1, 0};
    vecs[10] = '{150, 0,   20,  2,   20,    150,   0, -1, 0};
    vecs[11] = '{80,  10,  3,   2,   6,     1680,  0,  1, 1};
    vecs[12] = '{255, 127, 255, 127, 0,     0,     0, -1, 0};
    vecs[13] = '{0,   119, 160, 127, 160,   19040, 1, -1, 0};

    for (int a = 0; a < NPIX; a++) mem[a] = 3'(((a % SW) + (a / SW)) & 7);

    reset_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0;
`ifdef FRAME_REGION_MATCH_COUNT_EN
    match_colour = 3'd0;
`endif
    #23;
    check("reset_outputs", int'({mem_addr, pix_valid, pix_x, pix_y, pix_colour, busy, done}), 0);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", int'({busy, done, pix_valid}), 0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset in the middle of a full-screen scan.
    begin
      int seen;
      x0 = 8'd0; y0 = 7'd0; w = 8'd160; h = 7'd120; pix_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 30; k++) tick();
      check("busy_mid_scan", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_outputs", int'({mem_addr, pix_valid, pix_x, pix_y, pix_colour, busy, done}), 0);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (done || pix_valid || busy) seen++;
      end
      check("no_done_after_abort", seen, 0);
    end

`ifdef FRAME_REGION_MATCH_COUNT_EN
    begin
      vec_t mv;
      for (int a = 0; a < NPIX; a++) mem[a] = 3'b010;
      for (int x = 40; x < 120; x++) mem[x] = 3'b111;
      for (int x = 40; x < 60; x++) mem[SW + x] = 3'b111;
      for (int x = 0; x < 10; x++) mem[5 * SW + x] = 3'b111;
      match_colour = 3'b111;
      mv = '{40, 0, 80, 120, 9600, 40, 0, -1, 0};
      run_vec(mv);
      check("match_count", int'(match_count), 100);
      tick();
      check("match_count_hold", int'(match_count), 100);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
